// File: rtl/encoder_reader_pkg.sv
// Shared definitions for the quadrature encoder reader: register map,
// status bit layout, accumulator limits and the transition decoder.
package encoder_reader_pkg;

    localparam logic [1:0] ADDR_SPEED  = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_POS_LO = 2'd2;
    localparam logic [1:0] ADDR_POS_HI = 2'd3;

    localparam int STAT_ARMED = 0;
    localparam int STAT_ERR   = 1;
    localparam int STAT_DIR   = 2;

    localparam logic signed [11:0] NET_MAX = 12'sd2047;
    localparam logic signed [11:0] NET_MIN = -12'sd2047;
    localparam logic signed [12:0] SUM_MAX = 13'sd2047;
    localparam logic signed [12:0] SUM_MIN = -13'sd2047;

    // Position of a {B,A} pair in the forward cycle 00 -> 01 -> 11 -> 10.
    function automatic logic [1:0] quad_index(input logic [1:0] ba);
        logic [1:0] idx;
        case (ba)
            2'b00:   idx = 2'd0;
            2'b01:   idx = 2'd1;
            2'b11:   idx = 2'd2;
            2'b10:   idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Returns {illegal, delta[1:0]}; delta is 2-bit signed (+1 = 01, -1 = 11).
    function automatic logic [2:0] quad_decode(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        logic [1:0] step;
        logic [2:0] res;
        step = quad_index(cur_ab) - quad_index(prev_ab);
        case (step)
            2'd0:    res = 3'b000;
            2'd1:    res = 3'b001;
            2'd3:    res = 3'b011;
            default: res = 3'b100;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/encoder_reader_if.sv
// Byte-wide strobe register port between the PicoBlaze and the encoder reader.
interface encoder_reader_if;
    logic [1:0] motor_select;
    logic [1:0] reg_addr;
    logic       read_strobe;
    logic       clear_strobe;
    logic [7:0] data_out;
    logic       data_valid;

    modport master (
        output motor_select, reg_addr, read_strobe, clear_strobe,
        input  data_out, data_valid
    );

    modport slave (
        input  motor_select, reg_addr, read_strobe, clear_strobe,
        output data_out, data_valid
    );
endinterface

// File: rtl/encoder_reader_quad_channel.sv
// One encoder channel: pin synchronizer, quadrature decode, position
// counter, windowed net count with speed/direction latch, sticky error flag.
module quad_channel
    import encoder_reader_pkg::*;
#(
    parameter int PosWidth = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          ab_raw,
    input  logic                armed,
    input  logic                window_end,
    input  logic                clear_pos,
    input  logic                clear_err,
    output logic [PosWidth-1:0] pos,
    output logic [7:0]          speed,
    output logic                dir,
    output logic                err
);

    logic [1:0]          sync1_r;
    logic [1:0]          sync2_r;
    logic [1:0]          prev_ab_r;
    logic [PosWidth-1:0] pos_r;
    logic signed [11:0]  net_r;
    logic [7:0]          speed_r;
    logic                dir_r;
    logic                err_r;

    logic [2:0]          dec_s;
    logic                illegal_s;
    logic signed [11:0]  delta_s;
    logic signed [12:0]  sum_s;
    logic signed [11:0]  net_next_s;
    logic [11:0]         mag_s;
    logic [7:0]          speed_next_s;

    // Decode the synced pair against the previous one; nothing counts until armed.
    always_comb begin
        dec_s = quad_decode(prev_ab_r, sync2_r);
        if (armed) begin
            illegal_s = dec_s[2];
            delta_s   = {{10{dec_s[1]}}, dec_s[1:0]};
        end else begin
            illegal_s = 1'b0;
            delta_s   = 12'sd0;
        end
        sum_s = $signed({net_r[11], net_r}) + $signed({delta_s[11], delta_s});
        if (sum_s > SUM_MAX) begin
            net_next_s = NET_MAX;
        end else if (sum_s < SUM_MIN) begin
            net_next_s = NET_MIN;
        end else begin
            net_next_s = sum_s[11:0];
        end
        if (net_r[11]) begin
            mag_s = 12'(-net_r);
        end else begin
            mag_s = net_r;
        end
        if (mag_s > 12'd255) begin
            speed_next_s = 8'hFF;
        end else begin
            speed_next_s = mag_s[7:0];
        end
    end

    // Two-flop synchronizer followed by the previous-state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r   <= 2'b00;
            sync2_r   <= 2'b00;
            prev_ab_r <= 2'b00;
        end else begin
            sync1_r   <= ab_raw;
            sync2_r   <= sync1_r;
            prev_ab_r <= sync2_r;
        end
    end

    // Position counter; a clear discards any delta of the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_r <= {PosWidth{1'b0}};
        end else if (clear_pos) begin
            pos_r <= {PosWidth{1'b0}};
        end else begin
            pos_r <= pos_r + {{(PosWidth-12){delta_s[11]}}, delta_s};
        end
    end

    // Window accumulator; on the terminal cycle latch speed/dir and start the new window with this cycle's delta.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            net_r   <= 12'sd0;
            speed_r <= 8'h00;
            dir_r   <= 1'b0;
        end else if (window_end) begin
            net_r   <= delta_s;
            speed_r <= speed_next_s;
            dir_r   <= ~net_r[11];
        end else begin
            net_r   <= net_next_s;
        end
    end

    // Sticky illegal-transition flag; a new error beats a clear-on-read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else if (illegal_s) begin
            err_r <= 1'b1;
        end else if (clear_err) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    assign pos   = pos_r;
    assign speed = speed_r;
    assign dir   = dir_r;
    assign err   = err_r;

endmodule

// File: rtl/encoder_reader.sv
// Four-motor quadrature encoder reader with a byte-wide register read port.
// Holds the speed window counter, the post-reset arm delay, the position
// high-byte shadows and the read mux.
module encoder_reader
    import encoder_reader_pkg::*;
#(
    parameter int WindowCycles = 1000000,
    parameter int PosWidth     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        encoders,
    encoder_reader_if.slave   bus,
    output logic [3:0]        error_flags
);

    localparam int WIN_W = (WindowCycles > 1) ? $clog2(WindowCycles) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WindowCycles - 1);

    logic [1:0]                arm_cnt_r;
    logic [WIN_W-1:0]          win_cnt_r;
    logic [3:0][7:0]           shadow_r;
    logic [7:0]                data_out_r;
    logic                      data_valid_r;

    logic                      armed_s;
    logic                      window_end_s;
    logic [3:0]                sel_oh_s;
    logic [3:0]                clear_pos_s;
    logic [3:0]                clear_err_s;
    logic [7:0]                status_s;
    logic [7:0]                rd_data_s;
    logic [3:0][PosWidth-1:0]  pos_s;
    logic [3:0][7:0]           speed_s;
    logic [3:0]                dir_s;
    logic [3:0]                err_s;

    assign armed_s      = (arm_cnt_r == 2'd3);
    assign window_end_s = (win_cnt_r == WIN_LAST);

    // Hold decode off for three cycles after reset so prev_ab catches up with the pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arm_cnt_r <= 2'd0;
        end else if (arm_cnt_r != 2'd3) begin
            arm_cnt_r <= arm_cnt_r + 2'd1;
        end else begin
            arm_cnt_r <= arm_cnt_r;
        end
    end

    // Global speed-measurement window counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt_r <= {WIN_W{1'b0}};
        end else if (window_end_s) begin
            win_cnt_r <= {WIN_W{1'b0}};
        end else begin
            win_cnt_r <= win_cnt_r + WIN_W'(1);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_chan
        quad_channel #(.PosWidth(PosWidth)) u_chan (
            .clk        (clk),
            .reset      (reset),
            .ab_raw     (encoders[2*g +: 2]),
            .armed      (armed_s),
            .window_end (window_end_s),
            .clear_pos  (clear_pos_s[g]),
            .clear_err  (clear_err_s[g]),
            .pos        (pos_s[g]),
            .speed      (speed_s[g]),
            .dir        (dir_s[g]),
            .err        (err_s[g])
        );
    end

    // Per-motor control strobes and the read data mux for the selected motor.
    always_comb begin
        sel_oh_s    = 4'b0001 << bus.motor_select;
        clear_pos_s = 4'b0000;
        clear_err_s = 4'b0000;
        if (bus.clear_strobe) begin
            clear_pos_s = sel_oh_s;
        end else begin
            clear_pos_s = 4'b0000;
        end
        if (bus.read_strobe && (bus.reg_addr == ADDR_STATUS)) begin
            clear_err_s = sel_oh_s;
        end else begin
            clear_err_s = 4'b0000;
        end
        status_s             = 8'h00;
        status_s[STAT_ARMED] = armed_s;
        status_s[STAT_ERR]   = err_s[bus.motor_select];
        status_s[STAT_DIR]   = dir_s[bus.motor_select];
        case (bus.reg_addr)
            ADDR_SPEED:  rd_data_s = speed_s[bus.motor_select];
            ADDR_STATUS: rd_data_s = status_s;
            ADDR_POS_LO: rd_data_s = pos_s[bus.motor_select][7:0];
            ADDR_POS_HI: rd_data_s = shadow_r[bus.motor_select];
            default:     rd_data_s = 8'h00;
        endcase
    end

    // Capture the high byte alongside a low-byte read so a 16-bit read is coherent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_r <= 32'h0000_0000;
        end else if (bus.read_strobe && (bus.reg_addr == ADDR_POS_LO)) begin
            shadow_r[bus.motor_select] <= pos_s[bus.motor_select][15:8];
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Registered read response: one-cycle valid pulse, data held between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_r   <= 8'h00;
            data_valid_r <= 1'b0;
        end else begin
            data_valid_r <= bus.read_strobe;
            if (bus.read_strobe) begin
                data_out_r <= rd_data_s;
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.data_valid = data_valid_r;
    assign error_flags    = err_s;

endmodule

// File: tb/tb_encoder_reader.sv
// Directed bench for encoder_reader: reset state, position counting and
// wrap, windowed speed/direction, error flag handling, shadow/clear and
// reset in the middle of a read.
module tb_encoder_reader;

    localparam int W = 400;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] encoders = 8'hFF;
    logic [3:0] error_flags;

    encoder_reader_if bus();

    encoder_reader #(.WindowCycles(W), .PosWidth(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .encoders    (encoders),
        .bus         (bus),
        .error_flags (error_flags)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int idx [4];
    int tb_win = 0;
    logic [7:0] d;
    logic       v;

    // Bench copy of the window position, used only to place stimulus inside a window.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_win <= 0;
        else        tb_win <= (tb_win == W - 1) ? 0 : tb_win + 1;
    end

    function automatic logic [1:0] gray(input int i);
        case (i & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic step(input int m, input int dr);
        idx[m] = (idx[m] + dr) & 3;
        encoders[2*m +: 2] = gray(idx[m]);
        @(negedge clk);
    endtask

    task automatic settle();
        repeat (5) @(negedge clk);
    endtask

    task automatic rd(input int m, input logic [1:0] a, output logic [7:0] dd, output logic vv);
        bus.motor_select = 2'(m);
        bus.reg_addr     = a;
        bus.read_strobe  = 1'b1;
        @(negedge clk);
        bus.read_strobe  = 1'b0;
        dd = bus.data_out;
        vv = bus.data_valid;
    endtask

    task automatic wait_win(input int t);
        int n;
        n = 0;
        while (tb_win != t && n < 2 * W) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (tb_win != t) begin
            bad++;
            $display("FAIL wait_win: got win=%0d want %0d", tb_win, t);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        encoders = 8'hFF;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.data_valid, bus.data_out, error_flags} !== 13'h0) begin
            bad++;
            $display("FAIL reset_state: got v=%b d=%h e=%b want 0/00/0000", bus.data_valid, bus.data_out, error_flags);
        end
        reset = 1'b1;
        repeat (20) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            idx[m] = 2;
            rd(m, 2'd1, d, v);
            total++;
            if ({v, d} !== {1'b1, 8'h01}) begin
                bad++;
                $display("FAIL reset_status m%0d: got v=%b d=%h want v=1 d=01", m, v, d);
            end
            rd(m, 2'd2, d, v);
            total++;
            if ({v, d} !== {1'b1, 8'h00}) begin
                bad++;
                $display("FAIL reset_pos_lo m%0d: got v=%b d=%h want v=1 d=00", m, v, d);
            end
            rd(m, 2'd3, d, v);
            total++;
            if ({v, d} !== {1'b1, 8'h00}) begin
                bad++;
                $display("FAIL reset_pos_hi m%0d: got v=%b d=%h want v=1 d=00", m, v, d);
            end
        end
        @(negedge clk);
        total++;
        if (bus.data_valid !== 1'b0 || error_flags !== 4'b0000) begin
            bad++;
            $display("FAIL valid_pulse: got v=%b e=%b want v=0 e=0000", bus.data_valid, error_flags);
        end
    endtask

    task automatic test_position();
        for (int i = 0; i < 40; i++) step(1, 1);
        settle();
        rd(1, 2'd2, d, v);
        total++;
        if ({v, d} !== {1'b1, 8'h28}) begin
            bad++;
            $display("FAIL fwd_pos_lo: got v=%b d=%h want v=1 d=28", v, d);
        end
        rd(1, 2'd3, d, v);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("FAIL fwd_pos_hi: got %h want 00", d);
        end
        for (int i = 0; i < 41; i++) step(1, -1);
        settle();
        rd(1, 2'd2, d, v);
        total++;
        if (d !== 8'hFF) begin
            bad++;
            $display("FAIL wrap_pos_lo: got %h want FF", d);
        end
        rd(1, 2'd3, d, v);
        total++;
        if (d !== 8'hFF) begin
            bad++;
            $display("FAIL wrap_pos_hi: got %h want FF", d);
        end
        total++;
        if (error_flags !== 4'b0000) begin
            bad++;
            $display("FAIL pos_no_err: got %b want 0000", error_flags);
        end
    endtask

    task automatic test_speed();
        wait_win(5);
        for (int i = 0; i < 30; i++) step(2, 1);
        wait_win(10);
        rd(2, 2'd0, d, v);
        total++;
        if (d !== 8'd30) begin
            bad++;
            $display("FAIL speed_fwd: got %0d want 30", d);
        end
        rd(2, 2'd1, d, v);
        total++;
        if (d !== 8'h05) begin
            bad++;
            $display("FAIL status_fwd: got %h want 05", d);
        end
        for (int i = 0; i < 300; i++) step(2, -1);
        wait_win(10);
        rd(2, 2'd0, d, v);
        total++;
        if (d !== 8'd255) begin
            bad++;
            $display("FAIL speed_sat: got %0d want 255", d);
        end
        rd(2, 2'd1, d, v);
        total++;
        if (d !== 8'h01) begin
            bad++;
            $display("FAIL status_rev: got %h want 01", d);
        end
    endtask

    task automatic test_error();
        encoders[1:0] = 2'b00;
        idx[0] = 0;
        @(negedge clk);
        settle();
        total++;
        if (error_flags !== 4'b0001) begin
            bad++;
            $display("FAIL err_set: got %b want 0001", error_flags);
        end
        rd(0, 2'd2, d, v);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("FAIL err_pos_lo: got %h want 00", d);
        end
        rd(0, 2'd1, d, v);
        total++;
        if (d !== 8'h07 || error_flags !== 4'b0000) begin
            bad++;
            $display("FAIL err_read_clear: got d=%h e=%b want d=07 e=0000", d, error_flags);
        end
        rd(0, 2'd1, d, v);
        total++;
        if (d !== 8'h05) begin
            bad++;
            $display("FAIL err_second_read: got %h want 05", d);
        end
        // illegal 00 -> 11 reaching decode in the same cycle as a status read
        encoders[1:0] = 2'b11;
        idx[0] = 2;
        @(negedge clk);
        @(negedge clk);
        rd(0, 2'd1, d, v);
        total++;
        if (d !== 8'h05 || error_flags !== 4'b0001) begin
            bad++;
            $display("FAIL err_coincident: got d=%h e=%b want d=05 e=0001", d, error_flags);
        end
        rd(0, 2'd1, d, v);
        total++;
        if (d !== 8'h07 || error_flags !== 4'b0000) begin
            bad++;
            $display("FAIL err_after_coincident: got d=%h e=%b want d=07 e=0000", d, error_flags);
        end
    endtask

    task automatic test_shadow_clear();
        for (int i = 0; i < 255; i++) step(3, 1);
        settle();
        rd(3, 2'd2, d, v);
        total++;
        if (d !== 8'hFF) begin
            bad++;
            $display("FAIL sh_pos_lo: got %h want FF", d);
        end
        step(3, 1);
        settle();
        rd(3, 2'd3, d, v);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("FAIL sh_stale_hi: got %h want 00", d);
        end
        rd(3, 2'd2, d, v);
        rd(3, 2'd3, d, v);
        total++;
        if (d !== 8'h01) begin
            bad++;
            $display("FAIL sh_new_hi: got %h want 01", d);
        end
        // forward edge reaching decode in the same cycle as clear_strobe
        idx[3] = (idx[3] + 1) & 3;
        encoders[7:6] = gray(idx[3]);
        @(negedge clk);
        @(negedge clk);
        bus.motor_select = 2'd3;
        bus.clear_strobe = 1'b1;
        @(negedge clk);
        bus.clear_strobe = 1'b0;
        settle();
        rd(3, 2'd2, d, v);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("FAIL clr_pos_lo: got %h want 00", d);
        end
        rd(3, 2'd3, d, v);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("FAIL clr_pos_hi: got %h want 00", d);
        end
        step(3, 1);
        step(3, 1);
        settle();
        bus.motor_select = 2'd3;
        bus.reg_addr     = 2'd2;
        bus.read_strobe  = 1'b1;
        bus.clear_strobe = 1'b1;
        @(negedge clk);
        bus.read_strobe  = 1'b0;
        bus.clear_strobe = 1'b0;
        total++;
        if ({bus.data_valid, bus.data_out} !== {1'b1, 8'h02}) begin
            bad++;
            $display("FAIL read_with_clear: got v=%b d=%h want v=1 d=02", bus.data_valid, bus.data_out);
        end
        rd(3, 2'd2, d, v);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("FAIL after_read_clear: got %h want 00", d);
        end
    endtask

    task automatic test_reset_midread();
        encoders[1:0] = 2'b00;
        idx[0] = 0;
        @(negedge clk);
        settle();
        total++;
        if (error_flags !== 4'b0001) begin
            bad++;
            $display("FAIL pre_reset_err: got %b want 0001", error_flags);
        end
        bus.motor_select = 2'd1;
        bus.reg_addr     = 2'd2;
        bus.read_strobe  = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        bus.read_strobe = 1'b0;
        total++;
        if ({bus.data_valid, bus.data_out, error_flags} !== 13'h0) begin
            bad++;
            $display("FAIL midread_reset: got v=%b d=%h e=%b want 0/00/0000", bus.data_valid, bus.data_out, error_flags);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        rd(1, 2'd2, d, v);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("FAIL rst_pos_lo: got %h want 00", d);
        end
        rd(1, 2'd3, d, v);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("FAIL rst_pos_hi: got %h want 00", d);
        end
        rd(2, 2'd0, d, v);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("FAIL rst_speed: got %h want 00", d);
        end
        rd(0, 2'd1, d, v);
        total++;
        if (d !== 8'h01 || error_flags !== 4'b0000) begin
            bad++;
            $display("FAIL rst_status: got d=%h e=%b want d=01 e=0000", d, error_flags);
        end
    endtask

    initial begin
        bus.motor_select = 2'd0;
        bus.reg_addr     = 2'd0;
        bus.read_strobe  = 1'b0;
        bus.clear_strobe = 1'b0;
        for (int m = 0; m < 4; m++) idx[m] = 2;
        test_reset();
        test_position();
        test_speed();
        test_error();
        test_shadow_clear();
        test_reset_midread();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
